fifo_sync_ram: RTL

//  Synchronous show-ahead FIFO controller with valid/ready write and read streams.

---
 rtl/fifo_sync_ram_pkg.sv | 13 +
 rtl/ram_s2p1c.sv | 24 ++
 rtl/fifo_sync_ram.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fifo_sync_ram_pkg.sv
// rtl/fifo_sync_ram_pkg.sv - shared constants, types and width helper for fifo_sync_ram
package fifo_sync_ram_pkg;

  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] skid_occ_t;

  // Occupancy spans 0..DEPTH+2, so the counter needs room for DEPTH+2 inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth + 3);
  endfunction

endpackage

// File: rtl/ram_s2p1c.sv
// rtl/ram_s2p1c.sv - simple dual-port single-clock RAM, port A write, port B registered read
module ram_s2p1c #(
  parameter  int WORD_WIDTH = 8,
  parameter  int WORD_COUNT = 16,
  localparam int ADDR_WIDTH = $clog2(WORD_COUNT)
) (
  input  logic                  clk_i,
  input  logic                  we_a_i,
  input  logic [ADDR_WIDTH-1:0] addr_a_i,
  input  logic [WORD_WIDTH-1:0] data_a_i,
  input  logic [ADDR_WIDTH-1:0] addr_b_i,
  output logic [WORD_WIDTH-1:0] data_b_o
);

  logic [WORD_WIDTH-1:0] r_mem [WORD_COUNT];

  always_ff @(posedge clk_i) begin
    if (we_a_i) begin
      r_mem[addr_a_i] <= data_a_i;
    end
    data_b_o <= r_mem[addr_b_i];
  end

endmodule

// File: rtl/fifo_sync_ram.sv
// rtl/fifo_sync_ram.sv - show-ahead FIFO over ram_s2p1c with a 2-entry output skid buffer
// Defining FIFO_LEVEL_EN adds the registered level_o occupancy output.
module fifo_sync_ram
  import fifo_sync_ram_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  flush_i,
  input  logic                  wr_valid_i,
  input  logic [WORD_WIDTH-1:0] wr_data_i,
  output logic                  wr_ready_o,
  output logic                  rd_valid_o,
  output logic [WORD_WIDTH-1:0] rd_data_o,
  input  logic                  rd_ready_i
`ifdef FIFO_LEVEL_EN
  ,
  output logic [level_width(DEPTH)-1:0] level_o
`endif
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH  = ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_WIDTH-1:0]  r_ram_count;
  logic [CNT_WIDTH-1:0]  w_ram_count_nxt;
  logic                  r_pending;
  logic                  r_wr_ready;
  skid_occ_t             r_skid_occ;
  skid_occ_t             w_skid_occ_nxt;
  skid_occ_t             w_skid_tail;
  logic [WORD_WIDTH-1:0] r_skid0;
  logic [WORD_WIDTH-1:0] r_skid1;
  logic [WORD_WIDTH-1:0] w_ram_q;
  logic                  w_wr_fire;
  logic                  w_pop;
  logic                  w_issue;

  assign w_wr_fire = wr_valid_i & r_wr_ready & rstn_i & ~flush_i;
  assign w_pop     = (r_skid_occ != '0) & rd_ready_i;

  // The pending read always lands in the skid next cycle, so room is judged
  // against words already owned by the skid plus the one in flight.
  assign w_skid_occ_nxt  = r_skid_occ + skid_occ_t'(r_pending) - skid_occ_t'(w_pop);
  assign w_skid_tail     = r_skid_occ - skid_occ_t'(w_pop);
  assign w_issue         = (r_ram_count != '0) && (w_skid_occ_nxt < skid_occ_t'(SKID_DEPTH));
  assign w_ram_count_nxt = r_ram_count + CNT_WIDTH'(w_wr_fire) - CNT_WIDTH'(w_issue);

  ram_s2p1c #(
    .WORD_WIDTH (WORD_WIDTH),
    .WORD_COUNT (DEPTH)
  ) u_ram (
    .clk_i    (clk_i),
    .we_a_i   (w_wr_fire),
    .addr_a_i (r_wr_ptr),
    .data_a_i (wr_data_i),
    .addr_b_i (r_rd_ptr),
    .data_b_o (w_ram_q)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i || flush_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_ram_count <= '0;
      r_pending   <= 1'b0;
      r_skid_occ  <= '0;
      r_wr_ready  <= rstn_i;
    end else begin
      if (w_wr_fire) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_ram_count <= w_ram_count_nxt;
      r_pending   <= w_issue;
      r_skid_occ  <= w_skid_occ_nxt;
      r_wr_ready  <= (w_ram_count_nxt != FULL_COUNT);
    end
  end

  // Skid data is left alone on flush so rd_data_o keeps its last value.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_skid0 <= '0;
      r_skid1 <= '0;
    end else if (!flush_i) begin
      if (w_pop && (r_skid_occ == skid_occ_t'(2))) begin
        r_skid0 <= r_skid1;
      end
      if (r_pending) begin
        if (w_skid_tail == '0) begin
          r_skid0 <= w_ram_q;
        end else begin
          r_skid1 <= w_ram_q;
        end
      end
    end
  end

  assign wr_ready_o = r_wr_ready;
  assign rd_valid_o = (r_skid_occ != '0);
  assign rd_data_o  = r_skid0;

`ifdef FIFO_LEVEL_EN
  localparam int LVL_WIDTH = level_width(DEPTH);

  logic [LVL_WIDTH-1:0] r_level;

  always_ff @(posedge clk_i) begin
    if (!rstn_i || flush_i) begin
      r_level <= '0;
    end else begin
      r_level <= LVL_WIDTH'(w_ram_count_nxt) + LVL_WIDTH'(w_issue) + LVL_WIDTH'(w_skid_occ_nxt);
    end
  end

  assign level_o = r_level;
`endif

endmodule
